uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo.sv | 110 +++++++++++
 tb/tb_uart_rx_fifo.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive-side byte buffer behind the UART receiver. Each rising edge of
//   rx_done stores rx_data. Bytes are popped through rd_en. The block reports
//   the fill level and keeps a sticky overflow flag for bytes that arrive while
//   the buffer is full.
//
//   Optional feature macro: UART_RX_FIFO_FWFT_EN (first-word fall-through).
//     undefined : registered read. A pop at edge N presents rd_data and a
//                 one-cycle rd_valid pulse during cycle N+1.
//     defined   : rd_data always shows the head entry, and rd_valid = ~empty.
//
// Ports
//   clk       system clock, shared with the receiver
//   rst       asynchronous active-high reset
//   rx_data   receiver byte, valid while rx_done is high
//   rx_done   receiver completion flag; only its rising edge writes
//   rd_en     pop request from the consumer
//   rd_data   byte read out of the buffer
//   rd_valid  rd_data is valid (meaning depends on the mode above)
//   empty     count == 0
//   full      count == DEPTH
//   count     number of stored entries
//   overflow  sticky: at least one byte was dropped
//   clr_ovf   synchronous clear of overflow
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        rx_data,
  input  logic                     rx_done,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              rx_done_q;
  logic              wr;
  logic              wr_ok;
  logic              rd_ok;

  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);

  // A level held high on rx_done yields exactly one write strobe.
  assign wr    = rx_done & ~rx_done_q;
  // full and empty come from the registered count. A pop in the same cycle
  // therefore cannot rescue a write that arrives while the buffer is full.
  assign wr_ok = wr & ~full;
  assign rd_ok = rd_en & ~empty;

  // The storage array has no reset; its contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_done_q <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
    end else begin
      rx_done_q <= rx_done;
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      // When a drop and a clear happen in the same cycle, the drop wins.
      if (wr & full)   overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_FWFT_EN
  // Show 0 while empty so that the reset value of rd_data is defined even
  // though the storage array is not reset.
  assign rd_valid = ~empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr];
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (rd_ok) rd_data <= mem[rd_ptr];
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] rx_data = '0;
  logic              rx_done = 1'b0;
  logic              rd_en = 1'b0;
  logic              clr_ovf = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              empty;
  logic              full;
  logic [4:0]        count;
  logic              overflow;

  uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .empty(empty), .full(full), .count(count), .overflow(overflow),
    .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a queue of stored bytes, plus what the read port should show.
  logic [7:0] q[$];
  logic       m_prev_done = 1'b0;
  logic       m_ovf = 1'b0;
  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_prev_done = 1'b0;
    m_ovf       = 1'b0;
    m_valid     = 1'b0;
    m_data      = 8'h00;
  endtask

  task automatic model_step(input logic d, input logic [7:0] dat, input logic r, input logic c);
    bit wr_evt, was_full, was_empty;
    wr_evt    = d && !m_prev_done;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    m_valid   = 1'b0;
    if (r && !was_empty) begin
      m_data  = q.pop_front();
      m_valid = 1'b1;
    end
    if (c) m_ovf = 1'b0;
    if (wr_evt) begin
      if (was_full) m_ovf = 1'b1;
      else q.push_back(dat);
    end
    m_prev_done = d;
  endtask

  task automatic compare();
    check("count", 32'(count), 32'(q.size()));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef UART_RX_FIFO_FWFT_EN
    check("rd_valid", 32'(rd_valid), 32'(q.size() != 0));
    check("rd_data", 32'(rd_data), (q.size() != 0) ? 32'(q[0]) : 32'h0);
`else
    check("rd_valid", 32'(rd_valid), 32'(m_valid));
    check("rd_data", 32'(rd_data), 32'(m_data));
`endif
  endtask

  task automatic cyc(input logic d, input logic [7:0] dat, input logic r, input logic c);
    rx_done = d; rx_data = dat; rd_en = r; clr_ovf = c;
    @(posedge clk); #1;
    model_step(d, dat, r, c);
    compare();
  endtask

  task automatic put(input logic [7:0] dat);
    cyc(1'b1, dat, 1'b0, 1'b0);
    cyc(1'b0, dat, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; rx_done = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0;
    #2;
    model_reset();
    compare();
    @(posedge clk); #1;
    compare();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_count", 32'(count), 32'h0);
    check("rst_empty", 32'(empty), 32'h1);
    check("rst_full", 32'(full), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    check("rst_rd_valid", 32'(rd_valid), 32'h0);
    check("rst_rd_data", 32'(rd_data), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Three single-byte pulses, then three back-to-back reads.
    put(8'h55); put(8'hA3); put(8'h0F);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    check("drain_empty", 32'(empty), 32'h1);

    // A level held for five cycles must produce exactly one write.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h7E, 1'b0, 1'b0);
    check("hold_count", 32'(count), 32'h1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Seventeen writes into sixteen entries; the last one overflows.
    for (int i = 0; i <= 16; i++) put(8'(i));
    check("ovf_full", 32'(full), 32'h1);
    check("ovf_flag", 32'(overflow), 32'h1);
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    check("ovf_sticky", 32'(overflow), 32'h1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_cleared", 32'(overflow), 32'h0);

    // A write and a read in the same cycle at count 4.
    for (int i = 0; i < 4; i++) put(8'hB0 + 8'(i));
    cyc(1'b1, 8'hC4, 1'b1, 1'b0);
    check("simul_count", 32'(count), 32'h4);
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // A read while empty is ignored; then reset mid-stream at count 3.
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    put(8'h11); put(8'h22); put(8'h33);
    check("pre_rst_count", 32'(count), 32'h3);
    do_reset();
    check("post_rst_count", 32'(count), 32'h0);
    check("post_rst_empty", 32'(empty), 32'h1);

    // A write into an empty buffer, with no read in the same cycle.
    put(8'h9A);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    // Randomised traffic. The read-rate phases drive the buffer both to full
    // and to empty.
    for (int ph = 0; ph < 12; ph++) begin
      int rd_pct;
      rd_pct = (ph % 3 == 0) ? 10 : ((ph % 3 == 1) ? 90 : 50);
      for (int i = 0; i < 250; i++) begin
        if ($urandom_range(0, 299) == 0) begin
          do_reset();
        end else begin
          cyc(1'($urandom_range(0, 2) != 0), 8'($urandom),
              1'($urandom_range(0, 99) < rd_pct), 1'($urandom_range(0, 19) == 0));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
